// File: rtl/bus_arbiter_decoder.sv
// rtl/bus_arbiter_decoder.sv - N-master / M-slave round-robin bus arbiter and slave decoder
//
// Purpose:
//   Arbitrates NUM_MASTERS requesters onto one shared slave bus. A winner is
//   picked round-robin. Its select, address and write data are latched. The
//   transfer is routed to one of NUM_SLAVES slaves through one-hot write/read
//   strobes, which stay up until the selected slave returns ready. The winner
//   then gets a one-cycle done pulse. It gets an error pulse instead when the
//   select is out of range or the ready timeout expires. All outputs are
//   registered.
//
// Ports:
//   clk, rst    - clock (rising edge), synchronous active-high reset
//   mst_req     - per-master request level, held until done/err
//   mst_wr      - per-master direction, 1 = write
//   mst_sel     - packed per-master slave index (SEL_WIDTH each)
//   mst_addr    - packed per-master address (ADDR_WIDTH each)
//   mst_wdata   - packed per-master write data (DATA_WIDTH each)
//   mst_gnt     - one-hot grant, held for the whole transaction
//   mst_done    - one-cycle completion pulse to the granted master
//   mst_err     - one-cycle error pulse to the granted master
//   mst_rdata   - last captured read data, valid with mst_done on reads
//   slv_addr    - latched address of the current transfer
//   slv_wdata   - latched write data of the current transfer
//   slv_wen     - one-hot slave write strobe
//   slv_ren     - one-hot slave read strobe
//   slv_ready   - per-slave completion
//   slv_rdata   - packed per-slave read data
module bus_arbiter_decoder #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int SEL_WIDTH   = 2,
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT     = 15
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            mst_req,
    input  logic [NUM_MASTERS-1:0]            mst_wr,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  mst_sel,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] mst_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] mst_wdata,
    output logic [NUM_MASTERS-1:0]            mst_gnt,
    output logic [NUM_MASTERS-1:0]            mst_done,
    output logic [NUM_MASTERS-1:0]            mst_err,
    output logic [DATA_WIDTH-1:0]             mst_rdata,
    output logic [ADDR_WIDTH-1:0]             slv_addr,
    output logic [DATA_WIDTH-1:0]             slv_wdata,
    output logic [NUM_SLAVES-1:0]             slv_wen,
    output logic [NUM_SLAVES-1:0]             slv_ren,
    input  logic [NUM_SLAVES-1:0]             slv_ready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  slv_rdata
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    wr_q, wr_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0]  gnt_q, gnt_d;
    logic [NUM_MASTERS-1:0]  done_q, done_d;
    logic [NUM_MASTERS-1:0]  err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NUM_SLAVES-1:0]   wen_q, wen_d;
    logic [NUM_SLAVES-1:0]   ren_q, ren_d;

    logic                    rr_found;
    logic [IDX_W-1:0]        rr_pick;
    logic                    pick_wr;
    logic [SEL_WIDTH-1:0]    pick_sel;
    logic [ADDR_WIDTH-1:0]   pick_addr;
    logic [DATA_WIDTH-1:0]   pick_wdata;
    logic [NUM_SLAVES-1:0]   pick_slv_oh;
    logic                    sel_ready;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic [CNT_W-1:0]        cnt_inc;

    function automatic logic [NUM_MASTERS-1:0] mst_onehot(input logic [IDX_W-1:0] i);
        logic [NUM_MASTERS-1:0] v;
        v = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (i == IDX_W'(m)) v[m] = 1'b1;
        end
        return v;
    endfunction

    // All-zero result means the select addresses no existing slave.
    function automatic logic [NUM_SLAVES-1:0] slv_onehot(input logic [SEL_WIDTH-1:0] s);
        logic [NUM_SLAVES-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (s == SEL_WIDTH'(k)) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Round-robin search from last+1 upward, wrapping: first pass covers the
    // masters above last, the second pass wraps to 0..last.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (!rr_found && mst_req[m] && (IDX_W'(m) > last_q)) begin
                rr_found = 1'b1;
                rr_pick  = IDX_W'(m);
            end
        end
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (!rr_found && mst_req[m] && (IDX_W'(m) <= last_q)) begin
                rr_found = 1'b1;
                rr_pick  = IDX_W'(m);
            end
        end
    end

    // Fields of the winning master.
    always_comb begin
        pick_wr    = 1'b0;
        pick_sel   = '0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (rr_pick == IDX_W'(m)) begin
                pick_wr    = mst_wr[m];
                pick_sel   = mst_sel[m*SEL_WIDTH +: SEL_WIDTH];
                pick_addr  = mst_addr[m*ADDR_WIDTH +: ADDR_WIDTH];
                pick_wdata = mst_wdata[m*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        pick_slv_oh = slv_onehot(pick_sel);
    end

    // Ready and read data of the latched slave only; other slaves are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q == SEL_WIDTH'(k)) begin
                sel_ready = slv_ready[k];
                sel_rdata = slv_rdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next state and registered outputs. Output registers are loaded with the
    // value they must show in the state being entered.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = '0;
        ren_d   = '0;
        cnt_inc = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    idx_d   = rr_pick;
                    wr_d    = pick_wr;
                    sel_d   = pick_sel;
                    addr_d  = pick_addr;
                    wdata_d = pick_wdata;
                    gnt_d   = mst_onehot(rr_pick);
                    cnt_d   = '0;
                    if (pick_slv_oh == '0) begin
                        state_d = ST_ERR;
                        err_d   = mst_onehot(rr_pick);
                    end else begin
                        state_d = ST_XFER;
                        wen_d   = pick_wr ? pick_slv_oh : '0;
                        ren_d   = pick_wr ? '0 : pick_slv_oh;
                    end
                end
            end
            ST_XFER: begin
                if (sel_ready) begin
                    if (!wr_q) rdata_d = sel_rdata;
                    state_d = ST_DONE;
                    done_d  = mst_onehot(idx_q);
                end else if ((TIMEOUT > 0) && (cnt_inc == CNT_LIMIT)) begin
                    cnt_d   = cnt_inc;
                    state_d = ST_ERR;
                    err_d   = mst_onehot(idx_q);
                end else begin
                    cnt_d = cnt_inc;
                    wen_d = wen_q;
                    ren_d = ren_q;
                end
            end
            ST_DONE, ST_ERR: begin
                // The master just served drops to lowest priority.
                state_d = ST_IDLE;
                last_d  = idx_q;
                gnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_RST;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= '0;
            ren_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
        end
    end

    assign mst_gnt   = gnt_q;
    assign mst_done  = done_q;
    assign mst_err   = err_q;
    assign mst_rdata = rdata_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;
    assign slv_wen   = wen_q;
    assign slv_ren   = ren_q;

endmodule
